// File: rtl/demux4_buffered.sv
// Registered 1-to-4 demultiplexer with per-channel output registers,
// addressed or strict round-robin routing, and per-channel delivery counters.
module demux4_buffered #(
   parameter int W     = 8,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [W-1:0]       in_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         sel,
   input  logic               rr_mode,
   output logic [4*W-1:0]     out_data,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [4*CNT_W-1:0] deliv_cnt,
   output logic [1:0]         rr_ptr
);

   logic [3:0][W-1:0]     data_q, data_d;
   logic [3:0]            valid_q, valid_d;
   logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]            rr_ptr_q, rr_ptr_d;

   logic [1:0] tgt;
   logic       accept;
   logic [3:0] drain;

   always_comb begin
      tgt      = rr_mode ? rr_ptr_q : sel;
      // Gated by rst_n so nothing is offered as accepted while reset is applied.
      in_ready = rst_n & (~valid_q[tgt] | out_ready[tgt]);
      accept   = in_valid & in_ready;
      drain    = valid_q & out_ready;
      data_d   = data_q;
      valid_d  = valid_q & ~drain;
      cnt_d    = cnt_q;
      for (int k = 0; k < 4; k++) begin
         cnt_d[k] = cnt_q[k] + CNT_W'(drain[k]);
         if (accept && (tgt == 2'(k))) begin
            data_d[k]  = in_data;
            valid_d[k] = 1'b1;
         end
      end
      rr_ptr_d = rr_ptr_q + 2'(accept & rr_mode);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q   <= '0;
         valid_q  <= '0;
         cnt_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         data_q   <= data_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign deliv_cnt = cnt_q;
   assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_demux4_buffered.sv
// Directed self-checking bench for demux4_buffered (W=8, CNT_W=4).
module tb_demux4_buffered;

   localparam int W     = 8;
   localparam int CNT_W = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [W-1:0]       in_data;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         sel;
   logic               rr_mode;
   logic [4*W-1:0]     out_data;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
   logic [4*CNT_W-1:0] deliv_cnt;
   logic [1:0]         rr_ptr;

   int checks   = 0;
   int failures = 0;

   demux4_buffered #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .rr_mode   (rr_mode),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .deliv_cnt (deliv_cnt),
      .rr_ptr    (rr_ptr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] dch(input int k);
      return out_data[k*W +: W];
   endfunction

   function automatic logic [CNT_W-1:0] cch(input int k);
      return deliv_cnt[k*CNT_W +: CNT_W];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      // reset with in_valid held high
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h5A;
      sel       = 2'd0;
      rr_mode   = 1'b0;
      out_ready = 4'b1111;
      #1;
      chk("rst_in_ready_0", in_ready, 0);
      tick();
      chk("rst_in_ready_1", in_ready, 0);
      tick();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_deliv_cnt", deliv_cnt, 0);
      chk("rst_rr_ptr", rr_ptr, 0);

      // addressed routing, all consumers ready
      rr_mode   = 1'b0;
      out_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'((i + 1) * 8'h11);
         sel      = 2'(i);
         #1;
         chk("addr_in_ready", in_ready, 1);
         tick();
         chk("addr_valid", out_valid[i], 1);
         chk("addr_data", dch(i), (i + 1) * 8'h11);
      end
      in_valid = 1'b0;
      tick();
      chk("addr_valid_empty", out_valid, 0);
      for (int i = 0; i < 4; i++) chk("addr_cnt", cch(i), 1);
      chk("addr_rr_hold", rr_ptr, 0);

      // backpressure and pass-through on ch2
      do_reset();
      rr_mode   = 1'b0;
      out_ready = 4'b1011;
      sel       = 2'd2;
      in_valid  = 1'b1;
      in_data   = 8'hA0;
      tick();
      chk("bp_load_data", dch(2), 8'hA0);
      chk("bp_load_valid", out_valid, 4'b0100);
      in_data = 8'hA1;
      #1;
      chk("bp_stall", in_ready, 0);
      tick();
      chk("bp_hold_data", dch(2), 8'hA0);
      chk("bp_hold_cnt", cch(2), 0);
      out_ready = 4'b1111;
      #1;
      chk("bp_release_ready", in_ready, 1);
      tick();
      chk("bp_pass_valid", out_valid[2], 1);
      chk("bp_pass_data", dch(2), 8'hA1);
      chk("bp_pass_cnt", cch(2), 1);
      in_valid = 1'b0;
      tick();
      chk("bp_drain_valid", out_valid, 0);
      chk("bp_drain_cnt", cch(2), 2);

      // round-robin distribution
      do_reset();
      rr_mode   = 1'b1;
      out_ready = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         sel      = 2'(3 - (i % 4));
         #1;
         chk("rr_ptr_pre", rr_ptr, i % 4);
         tick();
         chk("rr_valid", out_valid[i % 4], 1);
         chk("rr_data", dch(i % 4), i);
      end
      in_valid = 1'b0;
      chk("rr_ptr_end", rr_ptr, 2);
      // fill ch2 via addressed mode, then strict round-robin must stall on it
      rr_mode   = 1'b0;
      sel       = 2'd2;
      out_ready = 4'b1011;
      in_valid  = 1'b1;
      in_data   = 8'h66;
      tick();
      chk("rr_fill_ptr", rr_ptr, 2);
      rr_mode = 1'b1;
      sel     = 2'd0;
      in_data = 8'h77;
      #1;
      chk("rr_stall_ready", in_ready, 0);
      tick();
      chk("rr_stall_ptr", rr_ptr, 2);
      chk("rr_stall_data", dch(2), 8'h66);
      chk("rr_stall_ch0", out_valid[0], 0);
      in_valid = 1'b0;

      // mode switch keeps rr_ptr
      do_reset();
      out_ready = 4'b1111;
      rr_mode   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h30 + i);
         tick();
      end
      chk("ms_ptr_rr", rr_ptr, 3);
      rr_mode = 1'b0;
      sel     = 2'd0;
      for (int i = 0; i < 2; i++) begin
         in_data = 8'(8'h40 + i);
         tick();
         chk("ms_addr_data", dch(0), 8'h40 + i);
      end
      chk("ms_ptr_hold", rr_ptr, 3);
      rr_mode = 1'b1;
      in_data = 8'h50;
      tick();
      chk("ms_resume_valid", out_valid[3], 1);
      chk("ms_resume_data", dch(3), 8'h50);
      chk("ms_resume_ptr", rr_ptr, 0);
      in_valid = 1'b0;

      // delivery counter wrap on ch1 (CNT_W=4)
      do_reset();
      rr_mode   = 1'b0;
      sel       = 2'd1;
      out_ready = 4'b1111;
      in_valid  = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_data = 8'(i);
         tick();
      end
      chk("wrap_cnt16", cch(1), 0);
      in_valid = 1'b0;
      tick();
      chk("wrap_cnt17", cch(1), 1);
      chk("wrap_cnt0", cch(0), 0);
      chk("wrap_cnt2", cch(2), 0);
      chk("wrap_cnt3", cch(3), 0);
      chk("wrap_valid", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
